// File: rtl/avl_pkg.sv
// ---------------------------------------------------------------------------
// avl_pkg
// Shared types and constants for the Avalon-MM load/store master.
//   size_t       : request size encoding (BYTE/HALF/WORD; 2'd3 is illegal)
//   lsu_state_t  : controller states
//   AVL_WORD_BYTES : bytes per Avalon data word
// ---------------------------------------------------------------------------
package avl_pkg;

  localparam int AVL_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER1 = 2'd1,
    XFER2 = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/avl_lane_align.sv
// ---------------------------------------------------------------------------
// avl_lane_align
// Combinational lane steering for the load/store master.
//   offset    in  2   byte offset within the word (addr[1:0])
//   size      in  2   access size (size_t encoding)
//   is_signed in  1   sign-extend load data
//   wdata     in  32  right-justified store data
//   rd_pair   in  64  {second word, first word} of load data
//   wide_be   out 8   byteenable across two words (low nibble = word 1)
//   wide_wd   out 64  store data shifted across two words
//   split     out 1   access crosses a word boundary (offset + bytes > 4)
//   ld_data   out 32  extracted and extended load data
// ---------------------------------------------------------------------------
module avl_lane_align
  import avl_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [63:0] rd_pair,
  output logic [7:0]  wide_be,
  output logic [63:0] wide_wd,
  output logic        split,
  output logic [31:0] ld_data
);

  logic [3:0]  n_bytes;
  logic [3:0]  mask;
  logic [31:0] shifted;

  always_comb begin
    n_bytes = 4'd1 << size;
    case (size)
      BYTE:    mask = 4'b0001;
      HALF:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    wide_be = {4'b0000, mask} << offset;
    wide_wd = {32'h0, wdata} << {offset, 3'b000};
    split   = ({2'b00, offset} + n_bytes) > 4'(AVL_WORD_BYTES);
    shifted = rd_pair[{offset, 3'b000} +: 32];
    case (size)
      BYTE:    ld_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      HALF:    ld_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/avl_master_lsu.sv
// ---------------------------------------------------------------------------
// avl_master_lsu
// Avalon-MM master turning CPU load/store requests into word-aligned bus
// transfers. Optional macro AVL_MISALIGN_SPLIT_EN: when defined, accesses
// crossing a word boundary run as two transfers; otherwise they are
// rejected with resp_err and no bus activity.
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake
//   req_write/size/signed/addr/wdata   request fields
//   resp_valid/resp_rdata/resp_err     one-cycle completion
//   address/byteenable/writedata       Avalon command
//   read/write/readdata/waitrequest    Avalon strobes and response
//
// state | meaning
// IDLE  | ready for a request, bus idle
// XFER1 | first (or only) bus transfer, held until waitrequest drops
// XFER2 | second word of a split access
// RESP  | resp_valid pulse, then back to IDLE
// ---------------------------------------------------------------------------
module avl_master_lsu
  import avl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        read,
  output logic        write,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  lsu_state_t  state;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        wr_q;
  logic [31:0] rd1;

  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_sgn;
  logic [63:0] rd_pair;
  logic [7:0]  wide_be;
  logic [63:0] wide_wd;
  logic        split_w;
  logic [31:0] ld_data;

`ifdef AVL_MISALIGN_SPLIT_EN
  logic [31:0] rd2;
  logic        split_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q;
  // The word arriving this cycle is fed straight through so the response
  // can be formed on the same edge that captures it.
  assign rd_pair = {(state == XFER2) ? readdata : rd2,
                    (state == XFER1) ? readdata : rd1};
`else
  logic unused_hi;
  assign unused_hi = ^{wide_be[7:4], wide_wd[63:32]};
  assign rd_pair   = {32'h0, (state == XFER1) ? readdata : rd1};
`endif

  // Steering uses the live request while idle and the latched one afterwards.
  assign al_off  = (state == IDLE) ? req_addr[1:0] : off_q;
  assign al_size = (state == IDLE) ? req_size      : size_q;
  assign al_sgn  = (state == IDLE) ? req_signed    : sgn_q;

  avl_lane_align u_align (
    .offset    (al_off),
    .size      (al_size),
    .is_signed (al_sgn),
    .wdata     (req_wdata),
    .rd_pair   (rd_pair),
    .wide_be   (wide_be),
    .wide_wd   (wide_wd),
    .split     (split_w),
    .ld_data   (ld_data)
  );

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sgn_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd1        <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      address    <= 32'h0;
      byteenable <= 4'h0;
      writedata  <= 32'h0;
      read       <= 1'b0;
      write      <= 1'b0;
`ifdef AVL_MISALIGN_SPLIT_EN
      rd2        <= 32'h0;
      split_q    <= 1'b0;
      be_hi_q    <= 4'h0;
      wd_hi_q    <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          if (req_valid) begin
            off_q  <= req_addr[1:0];
            size_q <= req_size;
            sgn_q  <= req_signed;
            wr_q   <= req_write;
`ifdef AVL_MISALIGN_SPLIT_EN
            split_q <= split_w;
            be_hi_q <= wide_be[7:4];
            wd_hi_q <= req_write ? wide_wd[63:32] : 32'h0;
            if (req_size == 2'd3) begin
`else
            if (req_size == 2'd3 || split_w) begin
`endif
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= XFER1;
              address    <= {req_addr[31:2], 2'b00};
              byteenable <= wide_be[3:0];
              writedata  <= req_write ? wide_wd[31:0] : 32'h0;
              read       <= ~req_write;
              write      <= req_write;
            end
          end
        end
        XFER1: begin
          if (!waitrequest) begin
            rd1 <= readdata;
`ifdef AVL_MISALIGN_SPLIT_EN
            if (split_q) begin
              state      <= XFER2;
              address    <= address + 32'd4;
              byteenable <= be_hi_q;
              writedata  <= wd_hi_q;
            end else
`endif
            begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= wr_q ? 32'h0 : ld_data;
              address    <= 32'h0;
              byteenable <= 4'h0;
              writedata  <= 32'h0;
              read       <= 1'b0;
              write      <= 1'b0;
            end
          end
        end
`ifdef AVL_MISALIGN_SPLIT_EN
        XFER2: begin
          if (!waitrequest) begin
            rd2        <= readdata;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= wr_q ? 32'h0 : ld_data;
            address    <= 32'h0;
            byteenable <= 4'h0;
            writedata  <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
          end
        end
`endif
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
